// File: rtl/axis_pkt_buffer.sv
// axis_pkt_buffer
//   Store-and-forward AXI4-Stream packet buffer. Beats are written into a
//   dual-port RAM and become visible on the master side only after the tlast
//   beat of their packet has been written. A packet that overflows the buffer
//   is either back-pressured (drop_en = 0) or discarded (drop_en = 1). An
//   oversize packet, one that fills the buffer with no committed packet ahead
//   of it, is always discarded.
//
// Ports
//   aclk, resetn             clock, asynchronous active-low reset
//   drop_en                  1 = discard an overflowing packet, 0 = back-pressure
//   s_axis_t{valid,ready,data,last}  upstream slave stream
//   m_axis_t{valid,ready,data,last}  downstream master stream
//   pkt_count                committed packets currently held
//   drop_count               packets discarded since reset, saturating
module axis_pkt_buffer #(
  parameter int TDATA_WIDTH = 16,
  parameter int DEPTH       = 1024
) (
  input  logic                       aclk,
  input  logic                       resetn,
  input  logic                       drop_en,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                       s_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic [$clog2(DEPTH):0]     pkt_count,
  output logic [15:0]                drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] FILL_FULL = {1'b1, {AW{1'b0}}};

  typedef enum logic [0:0] {
    ST_WRITE   = 1'b0,
    ST_DISCARD = 1'b1
  } wr_state_t;

  wr_state_t state_r, state_nxt_s;

  logic [TDATA_WIDTH:0] mem_r [DEPTH];
  logic [TDATA_WIDTH:0] ram_q_r;

  // rd_ptr_r counts beats handed to the downstream; fetch_ptr_r runs ahead of
  // it into the output stage, so beats parked there still occupy buffer space.
  logic [PW-1:0] wr_ptr_r, pkt_start_r, rd_ptr_r, fetch_ptr_r;
  logic [PW-1:0] fill_s, pkt_count_r;
  logic [15:0]   drop_count_r;
  logic          full_s, drop_s, s_ready_s, wr_en_s, commit_s;
  logic          fetch_s, pop_s, pop_last_s;
  logic [1:0]    occ_s;

  logic                   pend_valid_r;
  logic                   out_valid_r, out_last_r;
  logic [TDATA_WIDTH-1:0] out_data_r;
  logic                   skid_valid_r, skid_last_r;
  logic [TDATA_WIDTH-1:0] skid_data_r;

  assign fill_s     = wr_ptr_r - rd_ptr_r;
  assign full_s     = (fill_s == FILL_FULL);
  assign commit_s   = wr_en_s & s_axis_tlast;
  assign pop_s      = out_valid_r & m_axis_tready;
  assign pop_last_s = pop_s & out_last_r;

  // Output stage holds at most two beats; a fetch is allowed only when the
  // beat it returns next cycle is guaranteed a slot.
  assign occ_s   = {1'b0, out_valid_r} + {1'b0, skid_valid_r} + {1'b0, pend_valid_r};
  assign fetch_s = (fetch_ptr_r != pkt_start_r) & ((occ_s < 2'd2) | pop_s);

  // Write FSM next state, ready, write enable and drop detection.
  always_comb begin
    state_nxt_s = state_r;
    s_ready_s   = 1'b0;
    wr_en_s     = 1'b0;
    drop_s      = 1'b0;
    case (state_r)
      ST_WRITE: begin
        drop_s    = s_axis_tvalid & full_s & (drop_en | (pkt_count_r == PTR_ZERO));
        s_ready_s = ~full_s | drop_s;
        wr_en_s   = s_axis_tvalid & ~full_s;
        if (drop_s && !s_axis_tlast) begin
          state_nxt_s = ST_DISCARD;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_DISCARD: begin
        s_ready_s = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_DISCARD;
        end
      end
      default: begin
        state_nxt_s = ST_WRITE;
      end
    endcase
  end

  // FSM state, pointers and packet/drop counters.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_WRITE;
      wr_ptr_r     <= PTR_ZERO;
      pkt_start_r  <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      fetch_ptr_r  <= PTR_ZERO;
      pkt_count_r  <= PTR_ZERO;
      drop_count_r <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      // A drop rewinds to the packet start, releasing the partial packet.
      if (drop_s) begin
        wr_ptr_r <= pkt_start_r;
      end else if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (commit_s) begin
        pkt_start_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (fetch_s) begin
        fetch_ptr_r <= fetch_ptr_r + PTR_ONE;
      end
      if (drop_s && (drop_count_r != 16'hFFFF)) begin
        drop_count_r <= drop_count_r + 16'h0001;
      end
      case ({commit_s, pop_last_s})
        2'b10:   pkt_count_r <= pkt_count_r + PTR_ONE;
        2'b01:   pkt_count_r <= pkt_count_r - PTR_ONE;
        default: pkt_count_r <= pkt_count_r;
      endcase
    end
  end

  // Packet storage with registered read port.
  always_ff @(posedge aclk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
    if (fetch_s) begin
      ram_q_r <= mem_r[fetch_ptr_r[AW-1:0]];
    end
  end

  // Output register plus skid register absorbing the RAM read latency.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      pend_valid_r <= 1'b0;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      out_data_r   <= {TDATA_WIDTH{1'b0}};
      skid_valid_r <= 1'b0;
      skid_last_r  <= 1'b0;
      skid_data_r  <= {TDATA_WIDTH{1'b0}};
    end else begin
      pend_valid_r <= fetch_s;
      if (pop_s || !out_valid_r) begin
        if (skid_valid_r) begin
          out_valid_r  <= 1'b1;
          out_data_r   <= skid_data_r;
          out_last_r   <= skid_last_r;
          skid_valid_r <= 1'b0;
        end else if (pend_valid_r) begin
          out_valid_r <= 1'b1;
          out_data_r  <= ram_q_r[TDATA_WIDTH-1:0];
          out_last_r  <= ram_q_r[TDATA_WIDTH];
        end else begin
          out_valid_r <= 1'b0;
        end
      end else if (pend_valid_r) begin
        skid_valid_r <= 1'b1;
        skid_data_r  <= ram_q_r[TDATA_WIDTH-1:0];
        skid_last_r  <= ram_q_r[TDATA_WIDTH];
      end
    end
  end

  assign s_axis_tready = s_ready_s & resetn;
  assign m_axis_tvalid = out_valid_r;
  assign m_axis_tdata  = out_data_r;
  assign m_axis_tlast  = out_last_r;
  assign pkt_count     = pkt_count_r;
  assign drop_count    = drop_count_r;

endmodule

// File: tb/tb_axis_pkt_buffer.sv
module tb_axis_pkt_buffer;
  localparam int W = 16;
  localparam int D = 16;

  logic         aclk = 1'b0;
  logic         resetn = 1'b0;
  logic         drop_en = 1'b0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [W-1:0] s_axis_tdata = '0;
  logic         s_axis_tlast = 1'b0;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tlast;
  logic [4:0]   pkt_count;
  logic [15:0]  drop_count;

  always #5 aclk = ~aclk;

  axis_pkt_buffer #(.TDATA_WIDTH(W), .DEPTH(D)) dut (
    .aclk(aclk), .resetn(resetn), .drop_en(drop_en),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: committed beats awaiting output, beats of the packet
  // being received, and whether the rest of an overflowing packet is skipped.
  logic [W:0] exp_q[$];
  logic [W:0] part_q[$];
  bit         m_disc;
  int         m_pkts;
  int         m_drops;
  int         n_out = 0;
  int         cyc = 0;

  logic         smp_s_ready, smp_m_valid, smp_m_last, smp_pop;
  logic [W-1:0] smp_m_data;
  logic         prv_valid = 1'b0, prv_ready = 1'b0, prv_last = 1'b0;
  logic [W-1:0] prv_data = '0;

  typedef struct {
    int   len;
    logic de;
    int   exp_out;
    int   exp_drops;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    part_q.delete();
    m_disc  = 1'b0;
    m_pkts  = 0;
    m_drops = 0;
    prv_valid = 1'b0;
  endtask

  // One clock cycle: drive inputs, check combinational/held outputs at the
  // falling edge, advance the model on the rising edge, then check counters.
  task automatic do_cycle(input logic sv, input logic [W-1:0] sd, input logic sl, input logic mr);
    bit full, drop, rdy;
    logic [W:0] beat;
    s_axis_tvalid = sv;
    s_axis_tdata  = sd;
    s_axis_tlast  = sl;
    m_axis_tready = mr;
    @(negedge aclk);
    smp_s_ready = s_axis_tready;
    smp_m_valid = m_axis_tvalid;
    smp_m_data  = m_axis_tdata;
    smp_m_last  = m_axis_tlast;
    full = ((exp_q.size() + part_q.size()) == D);
    drop = !m_disc && sv && full && (drop_en || m_pkts == 0);
    rdy  = m_disc || !full || drop;
    chk("s_tready", int'(smp_s_ready), int'(rdy));
    if (exp_q.size() == 0) chk("m_valid_uncommitted", int'(smp_m_valid), 0);
    if (prv_valid && !prv_ready) begin
      chk("hold_valid", int'(smp_m_valid), 1);
      chk("hold_data", int'(smp_m_data), int'(prv_data));
      chk("hold_last", int'(smp_m_last), int'(prv_last));
    end
    smp_pop = smp_m_valid && mr;
    if (smp_pop && exp_q.size() > 0) begin
      beat = exp_q.pop_front();
      chk("m_data", int'(smp_m_data), int'(beat[W-1:0]));
      chk("m_last", int'(smp_m_last), int'(beat[W]));
      if (beat[W]) m_pkts--;
      n_out++;
    end
    prv_valid = smp_m_valid;
    prv_ready = mr;
    prv_data  = smp_m_data;
    prv_last  = smp_m_last;
    @(posedge aclk);
    if (sv && rdy) begin
      if (m_disc) begin
        if (sl) m_disc = 1'b0;
      end else if (drop) begin
        part_q.delete();
        if (m_drops < 65535) m_drops++;
        m_disc = !sl;
      end else begin
        part_q.push_back({sl, sd});
        if (sl) begin
          while (part_q.size() > 0) exp_q.push_back(part_q.pop_front());
          m_pkts++;
        end
      end
    end
    cyc++;
    #1;
    chk("pkt_count", int'(pkt_count), m_pkts);
    chk("drop_count", int'(drop_count), m_drops);
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic l, input logic mr);
    for (int i = 0; i < 100; i++) begin
      do_cycle(1'b1, d, l, mr);
      if (smp_s_ready) break;
    end
    chk("send_accept", int'(smp_s_ready), 1);
  endtask

  task automatic send_pkt(input int len, input logic [W-1:0] base, input logic mr);
    for (int i = 0; i < len; i++) send_beat(base + W'(i), (i == len - 1), mr);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      do_cycle(1'b0, '0, 1'b0, 1'b1);
    end
    chk("drain_empty", exp_q.size(), 0);
    do_cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  // Second packet meets a full buffer while the first one is held back.
  task automatic run_fill(input logic de);
    int n0, d0;
    drop_en = de;
    do_cycle(1'b0, '0, 1'b0, 1'b0);
    n0 = n_out;
    d0 = m_drops;
    send_pkt(10, 16'h0100, 1'b0);
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
      chk("fill_accept", int'(smp_s_ready), 1);
    end
    if (de) begin
      for (int i = 6; i < 10; i++) begin
        do_cycle(1'b1, 16'h0200 + 16'(i), (i == 9), 1'b0);
        chk("drop_consume", int'(smp_s_ready), 1);
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        do_cycle(1'b1, 16'h0206, 1'b0, 1'b0);
        chk("full_stall", int'(smp_s_ready), 0);
      end
      for (int i = 6; i < 10; i++) send_beat(16'h0200 + 16'(i), (i == 9), 1'b1);
    end
    drain();
    chk("fill_out_beats", n_out - n0, de ? 10 : 20);
    chk("fill_drop_count", int'(drop_count), d0 + (de ? 1 : 0));
    drop_en = 1'b0;
  endtask

  task automatic run_random(input logic de, input int ncyc);
    int len, idx, bias, guard;
    logic sv, sl, mr;
    logic [W-1:0] sd;
    len = 0; idx = 0; bias = 50; sv = 1'b0; sl = 1'b0; sd = '0;
    drop_en = de;
    for (int c = 0; c < ncyc; c++) begin
      if (c % 100 == 0) bias = ($urandom_range(0, 2) == 0) ? 10 : (($urandom_range(0, 1) == 0) ? 50 : 95);
      if (!sv) begin
        if (len == 0) begin
          len = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 24) : $urandom_range(1, 12);
          idx = 0;
        end
        if ($urandom_range(0, 3) != 0) begin
          sv = 1'b1;
          sd = 16'($urandom);
          sl = (idx == len - 1);
        end
      end
      mr = ($urandom_range(0, 99) < bias);
      do_cycle(sv, sd, sl, mr);
      if (sv && smp_s_ready) begin
        sv = 1'b0;
        idx++;
        if (sl) len = 0;
      end
    end
    guard = 0;
    while (len != 0 && guard < 300) begin
      if (!sv) begin
        sv = 1'b1;
        sd = 16'($urandom);
        sl = (idx == len - 1);
      end
      do_cycle(sv, sd, sl, 1'b1);
      if (sv && smp_s_ready) begin
        sv = 1'b0;
        idx++;
        if (sl) len = 0;
      end
      guard++;
    end
    chk("random_pkt_done", len, 0);
    drain();
    drop_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int wt, pops, first_pop, last_pop, peak, n0, dexp;
    bit early;
    logic [11:0] last_mask;

    vecs[0] = '{1,  1'b0, 1,  0};
    vecs[1] = '{8,  1'b0, 8,  0};
    vecs[2] = '{16, 1'b0, 16, 0};
    vecs[3] = '{17, 1'b0, 0,  1};
    vecs[4] = '{4,  1'b0, 4,  0};
    vecs[5] = '{20, 1'b1, 0,  1};
    vecs[6] = '{16, 1'b1, 16, 0};
    vecs[7] = '{5,  1'b1, 5,  0};

    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_m_valid", int'(m_axis_tvalid), 0);
    chk("rst_m_data", int'(m_axis_tdata), 0);
    chk("rst_m_last", int'(m_axis_tlast), 0);
    chk("rst_pkt_count", int'(pkt_count), 0);
    chk("rst_drop_count", int'(drop_count), 0);
    chk("rst_s_ready", int'(s_axis_tready), 0);
    @(negedge aclk);
    resetn = 1'b1;
    @(posedge aclk);
    #1;

    // Single 8-beat packet: nothing visible before commit, then streaming.
    early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_beat(16'(i), (i == 7), 1'b1);
      if (smp_m_valid) early = 1'b1;
    end
    chk("s1_no_early_valid", int'(early), 0);
    wt = 0;
    do begin
      do_cycle(1'b0, '0, 1'b0, 1'b1);
      wt++;
    end while (!smp_m_valid && wt < 6);
    chk("s1_latency_le3", int'(wt <= 3), 1);
    pops = 0;
    for (int i = 0; i < 7; i++) begin
      do_cycle(1'b0, '0, 1'b0, 1'b1);
      if (smp_pop) pops++;
    end
    chk("s1_consecutive", pops, 7);
    chk("s1_final_last", int'(smp_m_last), 1);
    drain();

    // Three back-to-back 4-beat packets: 12 beats with no gap.
    pops = 0; first_pop = -1; last_pop = 0; peak = 0; last_mask = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < 12) send_beat(16'h0A00 + 16'(i), (i % 4 == 3), 1'b1);
      else do_cycle(1'b0, '0, 1'b0, 1'b1);
      if (int'(pkt_count) > peak) peak = int'(pkt_count);
      if (smp_pop) begin
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (smp_m_last && pops < 12) last_mask[pops] = 1'b1;
        pops++;
      end
    end
    chk("s2_beats", pops, 12);
    chk("s2_no_gaps", last_pop - first_pop, 11);
    chk("s2_last_pos", int'(last_mask), 32'h888);
    chk("s2_peak_le3", int'(peak <= 3), 1);

    // Single-packet table vectors, including the full and oversize boundaries.
    dexp = m_drops;
    for (int v = 0; v < 8; v++) begin
      drop_en = vecs[v].de;
      do_cycle(1'b0, '0, 1'b0, 1'b1);
      n0 = n_out;
      send_pkt(vecs[v].len, 16'h3000 + 16'(v * 64), 1'b1);
      drain();
      dexp += vecs[v].exp_drops;
      chk("vec_out_beats", n_out - n0, vecs[v].exp_out);
      chk("vec_drop_count", int'(drop_count), dexp);
    end
    drop_en = 1'b0;

    run_fill(1'b0);
    run_fill(1'b1);

    // Reset with two committed packets and a third in progress.
    for (int p = 0; p < 2; p++) send_pkt(4, 16'h5A00 + 16'(p * 16), 1'b0);
    send_beat(16'h5A40, 1'b0, 1'b0);
    send_beat(16'h5A41, 1'b0, 1'b0);
    chk("pre_rst_pkt_count", int'(pkt_count), 2);
    #2;
    resetn = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    chk("mid_rst_m_valid", int'(m_axis_tvalid), 0);
    chk("mid_rst_m_data", int'(m_axis_tdata), 0);
    chk("mid_rst_m_last", int'(m_axis_tlast), 0);
    chk("mid_rst_pkt_count", int'(pkt_count), 0);
    chk("mid_rst_s_ready", int'(s_axis_tready), 0);
    model_reset();
    @(negedge aclk);
    @(negedge aclk);
    resetn = 1'b1;
    @(posedge aclk);
    #1;
    n0 = n_out;
    send_pkt(4, 16'h6600, 1'b1);
    drain();
    chk("post_rst_out_beats", n_out - n0, 4);

    run_random(1'b0, 1500);
    run_random(1'b1, 1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
